// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the interrupt controller slice.
//   irq_state_e  : controller FSM states (IDLE, ACTIVE, GAP)
//   DEFAULT_NSRC : default number of interrupt sources
//   DEFAULT_IDW  : default width of a source ID
// ---------------------------------------------------------------------------
package irq_pkg;

  // IDLE   : no request outstanding, arbitrating every cycle
  // ACTIVE : one source handed to the core, waiting for its mret
  // GAP    : single low cycle on interrupt so the core sees a fresh edge
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } irq_state_e;

  localparam int DEFAULT_NSRC = 8;
  localparam int DEFAULT_IDW  = $clog2(DEFAULT_NSRC);

endpackage : irq_pkg

// File: rtl/irq_if.sv
// ---------------------------------------------------------------------------
// irq_if
// Bundles the peripheral/core-facing signals of the interrupt controller.
//   irq_src     : raw peripheral interrupt lines (rising-edge significant)
//   mret        : core return-from-ISR strobe
//   mask_we     : mask write enable
//   mask_wdata  : new mask value, 1 = enabled
//   mask        : current mask register
//   pending     : current pending register
//   interrupt   : request to the core CSR unit
//   irq_id      : ID of the source in service
//   in_service  : high while an ISR is active
// The master modport is the system side (peripherals + core), the slave
// modport is the controller itself.
// ---------------------------------------------------------------------------
interface irq_if
  import irq_pkg::*;
#(
  parameter int NSRC = DEFAULT_NSRC,
  parameter int IDW  = $clog2(NSRC)
);

  logic [NSRC-1:0] irq_src;
  logic            mret;
  logic            mask_we;
  logic [NSRC-1:0] mask_wdata;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pending;
  logic            interrupt;
  logic [IDW-1:0]  irq_id;
  logic            in_service;

  modport master (
    output irq_src, mret, mask_we, mask_wdata,
    input  mask, pending, interrupt, irq_id, in_service
  );

  modport slave (
    input  irq_src, mret, mask_we, mask_wdata,
    output mask, pending, interrupt, irq_id, in_service
  );

endinterface : irq_if

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
// Combinational lowest-index-wins priority encoder.
//   req_i   : request vector
//   valid_o : at least one request bit set
//   id_o    : index of the lowest set bit (0 when valid_o is low)
// ---------------------------------------------------------------------------
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NSRC = DEFAULT_NSRC,
  parameter int IDW  = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req_i,
  output logic            valid_o,
  output logic [IDW-1:0]  id_o
);

  // Scan from the top index down so that the last hit, which is the
  // lowest set index, is the one that sticks.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = IDW'(i);
      end
    end
  end

endmodule : irq_prio_enc

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
// Edge-triggered, masked, lowest-index-priority interrupt controller with a
// single non-nesting service slot.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : irq_if slave modport (sources, mret, mask port, status outputs)
// ---------------------------------------------------------------------------
module irq_controller
  import irq_pkg::*;
#(
  parameter int NSRC = DEFAULT_NSRC,
  parameter int IDW  = $clog2(NSRC)
) (
  input  logic clk,
  input  logic rst_n,
  irq_if.slave bus
);

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr_vec;
  logic            win_valid;
  logic [IDW-1:0]  win_id;
  logic            take;

  irq_state_e      state_q;
  logic            interrupt_q;
  logic            in_service_q;
  logic [IDW-1:0]  irq_id_q;

  // Arbitration always sees the registered mask, so a mask write in the
  // same cycle as a decision only matters from the following edge on.
  irq_prio_enc #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_prio_enc (
    .req_i   (pending_q & mask_q),
    .valid_o (win_valid),
    .id_o    (win_id)
  );

  // A winner is taken whenever the slot is free. GAP arbitrates like IDLE:
  // it is already the one low cycle the core needs between two requests,
  // so back-to-back service shows interrupt low for exactly one cycle.
  assign take = (state_q != ACTIVE) && win_valid;
  assign rise = bus.irq_src & ~src_q;

  // Pending next-state: the winner's bit is cleared as it goes into
  // service, and a rise is ORed in afterwards so a set in the same cycle
  // as the clear wins.
  always_comb begin
    clr_vec   = take ? (NSRC'(1) << win_id) : '0;
    pending_d = (pending_q & ~clr_vec) | rise;
    mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
  end

  // Source history, pending and mask registers. src_q clears on reset so
  // a line already high at release counts as a fresh rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      src_q     <= bus.irq_src;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // Service FSM with registered outputs. irq_id only loads on entry to
  // ACTIVE, which keeps it stable for the whole ISR regardless of later
  // mask writes or new rises. mret is only honoured in ACTIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      interrupt_q  <= 1'b0;
      in_service_q <= 1'b0;
      irq_id_q     <= '0;
    end else begin
      case (state_q)
        IDLE, GAP: begin
          if (win_valid) begin
            state_q      <= ACTIVE;
            interrupt_q  <= 1'b1;
            in_service_q <= 1'b1;
            irq_id_q     <= win_id;
          end else begin
            state_q      <= IDLE;
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (bus.mret) begin
            state_q      <= GAP;
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          interrupt_q  <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mask       = mask_q;
  assign bus.pending    = pending_q;
  assign bus.interrupt  = interrupt_q;
  assign bus.irq_id     = irq_id_q;
  assign bus.in_service = in_service_q;

endmodule : irq_controller

// File: tb/tb_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_irq_controller
// Directed testbench for irq_controller with NSRC=8. Inputs are driven one
// posedge + 1 time unit after the edge, and outputs are sampled at the same
// point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_irq_controller;

  localparam int NSRC = 8;
  localparam int IDW  = 3;

  logic clk;
  logic rst_n;
  int   vecCount;
  int   errCount;

  irq_if #(.NSRC(NSRC), .IDW(IDW)) bus ();

  irq_controller #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle's worth of inputs and advances past the next edge.
  task automatic applyStimulus(input logic [7:0] src, input logic mr,
                               input logic we, input logic [7:0] wd);
    bus.irq_src    = src;
    bus.mret       = mr;
    bus.mask_we    = we;
    bus.mask_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  // Checks the full status picture at once.
  task automatic checkAll(input string tag, input logic intr, input logic [2:0] id,
                          input logic [7:0] pend);
    checkOutput({tag, ".interrupt"}, 32'(bus.interrupt), 32'(intr));
    checkOutput({tag, ".in_service"}, 32'(bus.in_service), 32'(intr));
    if (intr) checkOutput({tag, ".irq_id"}, 32'(bus.irq_id), 32'(id));
    checkOutput({tag, ".pending"}, 32'(bus.pending), 32'(pend));
  endtask

  // Main directed sequence.
  initial begin
    vecCount       = 0;
    errCount       = 0;
    rst_n          = 1'b0;
    bus.irq_src    = '0;
    bus.mret       = 1'b0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.interrupt", 32'(bus.interrupt), 32'd0);
    checkOutput("rst.in_service", 32'(bus.in_service), 32'd0);
    checkOutput("rst.irq_id", 32'(bus.irq_id), 32'd0);
    checkOutput("rst.pending", 32'(bus.pending), 32'd0);
    checkOutput("rst.mask", 32'(bus.mask), 32'd0);
    rst_n = 1'b1;

    // Single source, two-cycle latency, then mret and an ignored mret.
    applyStimulus(8'h00, 1'b0, 1'b1, 8'hFF);
    checkOutput("t1.mask", 32'(bus.mask), 32'hFF);
    applyStimulus(8'h08, 1'b0, 1'b0, 8'h00);
    checkAll("t1.e0", 1'b0, 3'd0, 8'h08);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    checkAll("t1.e1", 1'b1, 3'd3, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    checkAll("t1.hold", 1'b1, 3'd3, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
    checkAll("t1.gap", 1'b0, 3'd0, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    checkAll("t1.idle", 1'b0, 3'd0, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
    checkAll("t1.mret_idle", 1'b0, 3'd0, 8'h00);

    // Two simultaneous sources: lowest index first, one-cycle gap.
    applyStimulus(8'h24, 1'b0, 1'b0, 8'h00);
    checkAll("t2.pend", 1'b0, 3'd0, 8'h24);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    checkAll("t2.first", 1'b1, 3'd2, 8'h20);
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
    checkAll("t2.gap", 1'b0, 3'd0, 8'h20);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    checkAll("t2.second", 1'b1, 3'd5, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    checkAll("t2.idle", 1'b0, 3'd0, 8'h00);

    // Held level gives one event; a re-rise during ACTIVE is only recorded.
    applyStimulus(8'h10, 1'b0, 1'b0, 8'h00);
    checkAll("t3.pend", 1'b0, 3'd0, 8'h10);
    applyStimulus(8'h10, 1'b0, 1'b0, 8'h00);
    checkAll("t3.active", 1'b1, 3'd4, 8'h00);
    applyStimulus(8'h10, 1'b0, 1'b0, 8'h00);
    checkAll("t3.level", 1'b1, 3'd4, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    applyStimulus(8'h10, 1'b0, 1'b0, 8'h00);
    checkAll("t3.rerise", 1'b1, 3'd4, 8'h10);
    applyStimulus(8'h10, 1'b1, 1'b0, 8'h00);
    checkAll("t3.gap", 1'b0, 3'd0, 8'h10);
    applyStimulus(8'h10, 1'b0, 1'b0, 8'h00);
    checkAll("t3.reserve", 1'b1, 3'd4, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    checkAll("t3.idle", 1'b0, 3'd0, 8'h00);

    // Masked pending is retained; a rise on the cleared bit wins.
    applyStimulus(8'h00, 1'b0, 1'b1, 8'h00);
    applyStimulus(8'h40, 1'b0, 1'b0, 8'h00);
    checkAll("t4.masked", 1'b0, 3'd0, 8'h40);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    checkAll("t4.retain", 1'b0, 3'd0, 8'h40);
    applyStimulus(8'h00, 1'b0, 1'b1, 8'h40);
    checkAll("t4.oldmask", 1'b0, 3'd0, 8'h40);
    applyStimulus(8'h40, 1'b0, 1'b0, 8'h00);
    checkAll("t4.setwins", 1'b1, 3'd6, 8'h40);
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
    checkAll("t4.gap", 1'b0, 3'd0, 8'h40);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    checkAll("t4.again", 1'b1, 3'd6, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);

    // Mask write enables a held pending bit; mask write mid-ISR is harmless.
    applyStimulus(8'h00, 1'b0, 1'b1, 8'h00);
    applyStimulus(8'h02, 1'b0, 1'b0, 8'h00);
    checkAll("t5.masked", 1'b0, 3'd0, 8'h02);
    applyStimulus(8'h00, 1'b0, 1'b1, 8'h02);
    checkAll("t5.write", 1'b0, 3'd0, 8'h02);
    checkOutput("t5.mask", 32'(bus.mask), 32'h02);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    checkAll("t5.serve", 1'b1, 3'd1, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b1, 8'h00);
    checkAll("t5.maskactive", 1'b1, 3'd1, 8'h00);
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-ACTIVE, then a line high at release.
    applyStimulus(8'h00, 1'b0, 1'b1, 8'hFF);
    applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
    applyStimulus(8'h80, 1'b0, 1'b0, 8'h00);
    checkAll("t6.active", 1'b1, 3'd0, 8'h80);
    #2;
    rst_n       = 1'b0;
    bus.irq_src = 8'h01;
    #1;
    checkAll("t6.async", 1'b0, 3'd0, 8'h00);
    checkOutput("t6.mask", 32'(bus.mask), 32'h00);
    checkOutput("t6.irq_id", 32'(bus.irq_id), 32'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'h01, 1'b1, 1'b0, 8'h00);
    checkAll("t6.release", 1'b0, 3'd0, 8'h01);
    applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
    checkAll("t6.idle", 1'b0, 3'd0, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule : tb_irq_controller
